// File: rtl/mixer_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mixer_sequencer
// Purpose  : Per-tick frame controller: fetches two oscillator samples, drives
//            the mixer load/execute strobes and presents the result to a DAC.
// Revision : 1.0
// ============================================================================
module mixer_sequencer #(
    parameter int TIMEOUT   = 16,
    parameter int MAX_LEVEL = 5
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_tick,
    input  logic [7:0]  i_src1_data,
    input  logic        i_src1_valid,
    output logic        o_src1_req,
    input  logic [7:0]  i_src2_data,
    input  logic        i_src2_valid,
    output logic        o_src2_req,
    input  logic        i_cfg_write,
    input  logic [2:0]  i_cfg_level_1,
    input  logic [2:0]  i_cfg_level_2,
    output logic [7:0]  o_mix_sample_1,
    output logic        o_mix_sample_1_load,
    output logic [7:0]  o_mix_sample_2,
    output logic        o_mix_sample_2_load,
    output logic [2:0]  o_mix_level_1,
    output logic [2:0]  o_mix_level_2,
    output logic        o_mix_execute,
    input  logic [11:0] i_mix_output,
    output logic [11:0] o_dac_data,
    output logic        o_dac_valid,
    input  logic        i_dac_ready,
    output logic        o_busy,
    output logic        o_overrun,
    output logic [7:0]  o_underrun_count
);

    localparam int                 c_CNT_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_TO_LAST   = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [2:0]         c_LEVEL_MAX = 3'(MAX_LEVEL);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_REQ     = 3'd1;
    localparam logic [2:0] c_LOAD    = 3'd2;
    localparam logic [2:0] c_EXEC    = 3'd3;
    localparam logic [2:0] c_CAPTURE = 3'd4;
    localparam logic [2:0] c_PRESENT = 3'd5;

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_got1;
    logic               r_got2;
    logic [7:0]         r_cap1;
    logic [7:0]         r_cap2;
    logic [2:0]         r_shadow1;
    logic [2:0]         r_shadow2;
    logic [2:0]         r_snap1;
    logic [2:0]         r_snap2;

    logic               r_src1_req;
    logic               r_src2_req;
    logic [7:0]         r_mix_sample_1;
    logic [7:0]         r_mix_sample_2;
    logic               r_load1;
    logic               r_load2;
    logic [2:0]         r_level1;
    logic [2:0]         r_level2;
    logic               r_execute;
    logic [11:0]        r_dac_data;
    logic               r_dac_valid;
    logic               r_busy;
    logic               r_overrun;
    logic [7:0]         r_ucnt;

    logic               w_acc1;
    logic               w_acc2;
    logic               w_have1;
    logic               w_have2;
    logic               w_timeout;
    logic               w_req_done;
    logic [2:0]         w_lvl1;
    logic [2:0]         w_lvl2;

    // Acceptance in the current cycle counts towards completion, so a sample
    // arriving on the final timeout cycle is still used.
    assign w_acc1     = r_src1_req & i_src1_valid;
    assign w_acc2     = r_src2_req & i_src2_valid;
    assign w_have1    = r_got1 | w_acc1;
    assign w_have2    = r_got2 | w_acc2;
    assign w_timeout  = (r_cnt == c_TO_LAST);
    assign w_req_done = (w_have1 & w_have2) | w_timeout;

    assign w_lvl1 = (i_cfg_level_1 > c_LEVEL_MAX) ? c_LEVEL_MAX : i_cfg_level_1;
    assign w_lvl2 = (i_cfg_level_2 > c_LEVEL_MAX) ? c_LEVEL_MAX : i_cfg_level_2;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= c_IDLE;
            r_cnt          <= '0;
            r_got1         <= 1'b0;
            r_got2         <= 1'b0;
            r_cap1         <= '0;
            r_cap2         <= '0;
            r_shadow1      <= '0;
            r_shadow2      <= '0;
            r_snap1        <= '0;
            r_snap2        <= '0;
            r_src1_req     <= 1'b0;
            r_src2_req     <= 1'b0;
            r_mix_sample_1 <= '0;
            r_mix_sample_2 <= '0;
            r_load1        <= 1'b0;
            r_load2        <= 1'b0;
            r_level1       <= '0;
            r_level2       <= '0;
            r_execute      <= 1'b0;
            r_dac_data     <= '0;
            r_dac_valid    <= 1'b0;
            r_busy         <= 1'b0;
            r_overrun      <= 1'b0;
            r_ucnt         <= '0;
        end else begin
            r_overrun <= i_tick & (r_state != c_IDLE);

            if (i_cfg_write) begin
                r_shadow1 <= w_lvl1;
                r_shadow2 <= w_lvl2;
            end

            case (r_state)
                c_IDLE: begin
                    if (i_tick) begin
                        r_state    <= c_REQ;
                        r_busy     <= 1'b1;
                        r_cnt      <= '0;
                        r_got1     <= 1'b0;
                        r_got2     <= 1'b0;
                        r_src1_req <= 1'b1;
                        r_src2_req <= 1'b1;
                        // Levels are frozen at frame start so mid-frame writes
                        // only reach the mixer on the following frame.
                        r_snap1    <= r_shadow1;
                        r_snap2    <= r_shadow2;
                    end
                end

                c_REQ: begin
                    if (w_acc1) begin
                        r_cap1 <= i_src1_data;
                        r_got1 <= 1'b1;
                    end
                    if (w_acc2) begin
                        r_cap2 <= i_src2_data;
                        r_got2 <= 1'b1;
                    end
                    r_src1_req <= ~w_have1;
                    r_src2_req <= ~w_have2;
                    r_cnt      <= r_cnt + c_CNT_ONE;

                    if (w_req_done) begin
                        r_state        <= c_LOAD;
                        r_src1_req     <= 1'b0;
                        r_src2_req     <= 1'b0;
                        r_mix_sample_1 <= w_acc1 ? i_src1_data : r_cap1;
                        r_mix_sample_2 <= w_acc2 ? i_src2_data : r_cap2;
                        r_load1        <= 1'b1;
                        r_load2        <= 1'b1;
                        r_level1       <= r_snap1;
                        r_level2       <= r_snap2;
                        if (!(w_have1 & w_have2) && (r_ucnt != 8'hFF)) begin
                            r_ucnt <= r_ucnt + 8'd1;
                        end
                    end
                end

                c_LOAD: begin
                    r_state   <= c_EXEC;
                    r_load1   <= 1'b0;
                    r_load2   <= 1'b0;
                    r_execute <= 1'b1;
                end

                c_EXEC: begin
                    r_state   <= c_CAPTURE;
                    r_execute <= 1'b0;
                end

                c_CAPTURE: begin
                    r_state     <= c_PRESENT;
                    r_dac_data  <= i_mix_output;
                    r_dac_valid <= 1'b1;
                end

                c_PRESENT: begin
                    if (i_dac_ready) begin
                        r_state     <= c_IDLE;
                        r_dac_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end

                default: begin
                    r_state     <= c_IDLE;
                    r_busy      <= 1'b0;
                    r_src1_req  <= 1'b0;
                    r_src2_req  <= 1'b0;
                    r_load1     <= 1'b0;
                    r_load2     <= 1'b0;
                    r_execute   <= 1'b0;
                    r_dac_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_src1_req          = r_src1_req;
    assign o_src2_req          = r_src2_req;
    assign o_mix_sample_1      = r_mix_sample_1;
    assign o_mix_sample_1_load = r_load1;
    assign o_mix_sample_2      = r_mix_sample_2;
    assign o_mix_sample_2_load = r_load2;
    assign o_mix_level_1       = r_level1;
    assign o_mix_level_2       = r_level2;
    assign o_mix_execute       = r_execute;
    assign o_dac_data          = r_dac_data;
    assign o_dac_valid         = r_dac_valid;
    assign o_busy              = r_busy;
    assign o_overrun           = r_overrun;
    assign o_underrun_count    = r_ucnt;

endmodule
`default_nettype wire

// File: tb/tb_mixer_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mixer_sequencer
// Purpose  : Self-checking bench for mixer_sequencer with a frame-level model.
// Revision : 1.0
// ============================================================================
module tb_mixer_sequencer;

    localparam int TIMEOUT   = 16;
    localparam int MAX_LEVEL = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_tick = 1'b0;
    logic [7:0]  i_src1_data = '0;
    logic        i_src1_valid = 1'b0;
    logic [7:0]  i_src2_data = '0;
    logic        i_src2_valid = 1'b0;
    logic        i_cfg_write = 1'b0;
    logic [2:0]  i_cfg_level_1 = '0;
    logic [2:0]  i_cfg_level_2 = '0;
    logic [11:0] mix_out = '0;
    logic        i_dac_ready = 1'b0;

    logic        o_src1_req, o_src2_req;
    logic [7:0]  o_mix_sample_1, o_mix_sample_2;
    logic        o_mix_sample_1_load, o_mix_sample_2_load;
    logic [2:0]  o_mix_level_1, o_mix_level_2;
    logic        o_mix_execute;
    logic [11:0] o_dac_data;
    logic        o_dac_valid, o_busy, o_overrun;
    logic [7:0]  o_underrun_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Frame-level reference state
    int m_sh1, m_sh2, m_cap1, m_cap2, m_ucnt;

    mixer_sequencer #(.TIMEOUT(TIMEOUT), .MAX_LEVEL(MAX_LEVEL)) dut (
        .i_clock(clk), .i_reset(rst), .i_tick(i_tick),
        .i_src1_data(i_src1_data), .i_src1_valid(i_src1_valid), .o_src1_req(o_src1_req),
        .i_src2_data(i_src2_data), .i_src2_valid(i_src2_valid), .o_src2_req(o_src2_req),
        .i_cfg_write(i_cfg_write), .i_cfg_level_1(i_cfg_level_1), .i_cfg_level_2(i_cfg_level_2),
        .o_mix_sample_1(o_mix_sample_1), .o_mix_sample_1_load(o_mix_sample_1_load),
        .o_mix_sample_2(o_mix_sample_2), .o_mix_sample_2_load(o_mix_sample_2_load),
        .o_mix_level_1(o_mix_level_1), .o_mix_level_2(o_mix_level_2),
        .o_mix_execute(o_mix_execute), .i_mix_output(mix_out),
        .o_dac_data(o_dac_data), .o_dac_valid(o_dac_valid), .i_dac_ready(i_dac_ready),
        .o_busy(o_busy), .o_overrun(o_overrun), .o_underrun_count(o_underrun_count)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] mixf(input int s1, input int s2, input int l1, input int l2);
        return 12'(s1 * l1 + s2 * l2);
    endfunction

    function automatic int clampl(input logic [2:0] l);
        return (int'(l) > MAX_LEVEL) ? MAX_LEVEL : int'(l);
    endfunction

    // Mixer stand-in: result ready the cycle after execute
    always @(posedge clk) begin
        if (o_mix_execute) mix_out <= mixf(o_mix_sample_1, o_mix_sample_2, o_mix_level_1, o_mix_level_2);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        check(name, {o_src1_req, o_src2_req, o_mix_sample_1, o_mix_sample_1_load,
                     o_mix_sample_2, o_mix_sample_2_load, o_mix_level_1, o_mix_level_2,
                     o_mix_execute, o_dac_data, o_dac_valid, o_busy, o_overrun,
                     o_underrun_count}, 64'd0);
    endtask

    task automatic model_reset();
        m_sh1 = 0; m_sh2 = 0; m_cap1 = 0; m_cap2 = 0; m_ucnt = 0;
    endtask

    task automatic cfg_write(input logic [2:0] l1, input logic [2:0] l2);
        @(negedge clk);
        i_cfg_write = 1'b1; i_cfg_level_1 = l1; i_cfg_level_2 = l2;
        @(negedge clk);
        i_cfg_write = 1'b0;
        m_sh1 = clampl(l1); m_sh2 = clampl(l2);
    endtask

    // One full frame. dN = REQ-cycle offset at which source N raises valid
    // (negative: never). Returns what the DUT showed in LOAD.
    task automatic run_frame(input int d1, input int d2, input logic [7:0] a1, input logic [7:0] a2,
                             input int rdy_wait, input int tick_per, input bit wr_mid,
                             input logic [2:0] wl1, input logic [2:0] wl2,
                             output int out_dur, output logic [7:0] out_s1,
                             output logic [7:0] out_s2, output logic [7:0] out_u);
        bit p1, p2, got1, got2;
        int dur, e1, e2, eu, el1, el2, cyc, novr, eovr;
        logic [11:0] edac, held;
        p1  = (d1 >= 0) && (d1 < TIMEOUT);
        p2  = (d2 >= 0) && (d2 < TIMEOUT);
        dur = (p1 && p2) ? (((d1 > d2) ? d1 : d2) + 1) : TIMEOUT;
        e1  = p1 ? int'(a1) : m_cap1;
        e2  = p2 ? int'(a2) : m_cap2;
        eu  = (p1 && p2) ? m_ucnt : ((m_ucnt < 255) ? m_ucnt + 1 : 255);
        el1 = m_sh1; el2 = m_sh2;
        edac = mixf(e1, e2, el1, el2);
        m_cap1 = e1; m_cap2 = e2; m_ucnt = eu;
        if (wr_mid) begin m_sh1 = clampl(wl1); m_sh2 = clampl(wl2); end

        @(negedge clk);
        i_tick = 1'b1; i_src1_data = a1; i_src2_data = a2;
        @(negedge clk);
        i_tick = 1'b0;
        check("busy_in_req", o_busy, 1);
        got1 = 0; got2 = 0; cyc = 0;
        while (!o_mix_sample_1_load && cyc < 40) begin
            i_cfg_write = wr_mid && (cyc == 0);
            if (wr_mid && cyc == 0) begin i_cfg_level_1 = wl1; i_cfg_level_2 = wl2; end
            check("src1_req", o_src1_req, !got1);
            check("src2_req", o_src2_req, !got2);
            i_src1_valid = (d1 >= 0) && (cyc >= d1) && !got1;
            i_src2_valid = (d2 >= 0) && (cyc >= d2) && !got2;
            if (i_src1_valid && o_src1_req) got1 = 1;
            if (i_src2_valid && o_src2_req) got2 = 1;
            @(negedge clk);
            cyc++;
        end
        i_cfg_write = 1'b0; i_src1_valid = 1'b0; i_src2_valid = 1'b0;
        out_dur = cyc; out_s1 = o_mix_sample_1; out_s2 = o_mix_sample_2; out_u = o_underrun_count;
        check("load_cycle", cyc, dur);
        check("loads", {o_mix_sample_1_load, o_mix_sample_2_load, o_mix_execute}, 3'b110);
        check("sample1", o_mix_sample_1, e1);
        check("sample2", o_mix_sample_2, e2);
        check("levels", {o_mix_level_1, o_mix_level_2}, {3'(el1), 3'(el2)});
        check("underrun", o_underrun_count, eu);
        @(negedge clk);
        check("exec", {o_mix_sample_1_load, o_mix_sample_2_load, o_mix_execute}, 3'b001);
        @(negedge clk);
        check("capture", {o_mix_execute, o_dac_valid}, 2'b00);
        @(negedge clk);
        check("dac_valid", o_dac_valid, 1);
        check("dac_data", o_dac_data, edac);
        held = o_dac_data; novr = 0; eovr = 0;
        for (int k = 0; k < rdy_wait; k++) begin
            if (o_overrun) novr++;
            check("dac_hold", {o_dac_valid, o_dac_data}, {1'b1, held});
            i_tick = (tick_per > 0) && (k % tick_per == 0);
            if (i_tick) eovr++;
            @(negedge clk);
        end
        if (o_overrun) novr++;
        i_tick = 1'b0;
        check("overruns", novr, eovr);
        i_dac_ready = 1'b1;
        @(negedge clk);
        i_dac_ready = 1'b0;
        check("valid_clear", {o_dac_valid, o_busy}, 2'b00);
    endtask

    typedef struct {
        int d1; int d2; logic [7:0] a1; logic [7:0] a2; logic [2:0] l1; logic [2:0] l2;
        int exp_dur; logic [7:0] exp_s1; logic [7:0] exp_s2; logic [7:0] exp_u;
    } vec_t;

    vec_t tv[7];

    initial begin
        int dur;
        logic [7:0] s1, s2, u;
        tv[0] = '{0,  0,  8'h40, 8'h80, 3'd1, 3'd1, 1,  8'h40, 8'h80, 8'd0};
        tv[1] = '{3,  0,  8'h11, 8'h22, 3'd7, 3'd2, 4,  8'h11, 8'h22, 8'd0};
        tv[2] = '{2,  -1, 8'h33, 8'h44, 3'd3, 3'd6, 16, 8'h33, 8'h22, 8'd1};
        tv[3] = '{-1, -1, 8'h55, 8'h66, 3'd0, 3'd5, 16, 8'h33, 8'h22, 8'd2};
        tv[4] = '{15, 5,  8'h77, 8'h88, 3'd2, 3'd4, 16, 8'h77, 8'h88, 8'd2};
        tv[5] = '{16, 1,  8'h99, 8'hAA, 3'd5, 3'd1, 16, 8'h77, 8'hAA, 8'd3};
        tv[6] = '{1,  1,  8'hFF, 8'h01, 3'd4, 3'd4, 2,  8'hFF, 8'h01, 8'd3};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        rst = 1'b0;
        model_reset();

        for (int i = 0; i < 7; i++) begin
            cfg_write(tv[i].l1, tv[i].l2);
            run_frame(tv[i].d1, tv[i].d2, tv[i].a1, tv[i].a2, i % 3, 0, 1'b0, 3'd0, 3'd0,
                      dur, s1, s2, u);
            check("tv_dur", dur, tv[i].exp_dur);
            check("tv_s1", s1, tv[i].exp_s1);
            check("tv_s2", s2, tv[i].exp_s2);
            check("tv_u", u, tv[i].exp_u);
        end

        // Mid-frame level write: this frame keeps 1/1, next frame shows 5/3
        cfg_write(3'd1, 3'd1);
        run_frame(0, 0, 8'h10, 8'h20, 0, 0, 1'b1, 3'd7, 3'd3, dur, s1, s2, u);
        run_frame(0, 0, 8'h30, 8'h40, 0, 0, 1'b0, 3'd0, 3'd0, dur, s1, s2, u);
        check("cfg_next_frame", {o_mix_level_1, o_mix_level_2}, {3'd5, 3'd3});

        // DAC stalled 40 cycles with ticks every 10: four dropped ticks
        run_frame(0, 1, 8'h21, 8'h43, 40, 10, 1'b0, 3'd0, 3'd0, dur, s1, s2, u);
        repeat (3) begin
            @(negedge clk);
            check("no_extra_frame", o_busy, 0);
        end

        // Valid outside REQ is ignored
        @(negedge clk);
        i_src1_data = 8'h11; i_src1_valid = 1'b1;
        @(negedge clk);
        i_src1_valid = 1'b0;
        run_frame(2, 0, 8'h22, 8'h33, 0, 0, 1'b0, 3'd0, 3'd0, dur, s1, s2, u);
        check("spurious_valid", s1, 8'h22);

        // Randomized frames against the model
        for (int i = 0; i < 40; i++) begin
            int r1, r2;
            r1 = int'($urandom_range(0, 20)); if (r1 > 17) r1 = -1;
            r2 = int'($urandom_range(0, 20)); if (r2 > 17) r2 = -1;
            if ($urandom_range(0, 1) == 1) cfg_write(3'($urandom), 3'($urandom));
            run_frame(r1, r2, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 0,
                      1'($urandom), 3'($urandom), 3'($urandom), dur, s1, s2, u);
        end

        // Underrun counter saturation
        for (int i = 0; i < 256; i++) begin
            run_frame(-1, -1, 8'h00, 8'h00, 0, 0, 1'b0, 3'd0, 3'd0, dur, s1, s2, u);
        end
        check("underrun_sat", o_underrun_count, 8'd255);

        // Asynchronous reset during EXEC, then a clean frame
        @(negedge clk);
        i_tick = 1'b1; i_src1_data = 8'h5A; i_src2_data = 8'hA5;
        i_src1_valid = 1'b1; i_src2_valid = 1'b1;
        @(negedge clk);
        i_tick = 1'b0;
        @(negedge clk);
        i_src1_valid = 1'b0; i_src2_valid = 1'b0;
        check("pre_reset_load", o_mix_sample_1_load, 1);
        @(negedge clk);
        check("pre_reset_exec", o_mix_execute, 1);
        #1 rst = 1'b1;
        #1 check_zero("async_reset");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        run_frame(1, 2, 8'h12, 8'h34, 1, 0, 1'b0, 3'd0, 3'd0, dur, s1, s2, u);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mixer_sequencer.md
Name: mixer_sequencer

Overview:
Frame controller for the two-channel 8-bit digital mixer. On each sample-rate tick it fetches one sample from each oscillator source over a req/valid handshake and drives the mixer's load strobes, level settings and execute strobe. It then captures the 12-bit mix result and presents it to the DAC interface over a valid/ready handshake. It sits between the oscillator cores, the control-register block and the mixer/DAC path.

Parameters:
TIMEOUT, 16, cycles in REQ before a missing source sample is abandoned (min 2)
MAX_LEVEL, 5, upper clamp applied to written level values

Ports:
i_clock  in  1  system clock; all logic on posedge
i_reset  in  1  asynchronous, active-high reset
i_tick  in  1  sample-rate strobe, 1-cycle pulse
i_src1_data  in  8  oscillator 1 sample
i_src1_valid  in  1  oscillator 1 data valid
o_src1_req  out  1  request to oscillator 1
i_src2_data  in  8  oscillator 2 sample
i_src2_valid  in  1  oscillator 2 data valid
o_src2_req  out  1  request to oscillator 2
i_cfg_write  in  1  write strobe for level config
i_cfg_level_1  in  3  requested level, channel 1
i_cfg_level_2  in  3  requested level, channel 2
o_mix_sample_1  out  8  sample to mixer, channel 1
o_mix_sample_1_load  out  1  mixer load strobe, channel 1
o_mix_sample_2  out  8  sample to mixer, channel 2
o_mix_sample_2_load  out  1  mixer load strobe, channel 2
o_mix_level_1  out  3  active level to mixer, channel 1
o_mix_level_2  out  3  active level to mixer, channel 2
o_mix_execute  out  1  mixer execute strobe
i_mix_output  in  12  mixer result
o_dac_data  out  12  mixed sample to DAC
o_dac_valid  out  1  DAC data valid
i_dac_ready  in  1  DAC accepts data
o_busy  out  1  high whenever state != IDLE
o_overrun  out  1  1-cycle pulse: tick dropped
o_underrun_count  out  8  saturating count of frames with a timed-out source

Behaviour:
- Reset (async): state IDLE; all outputs 0; capture regs, shadow levels and timeout counter 0.
- States: IDLE, REQ, LOAD, EXEC, CAPTURE, PRESENT; all outputs registered.
- IDLE: i_tick -> REQ; timeout counter cleared; both got-flags cleared.
- REQ: o_srcN_req high while got-flag N is clear. Sample accepted on any cycle with req & valid: data into capture reg N, got-flag N set, req N drops next cycle. Valid without req is ignored.
- Leave REQ for LOAD when both flags are set, or when the counter reaches TIMEOUT-1. On timeout, a missing source keeps its previous capture value. o_underrun_count increments once per such frame, saturating at 255.
- LOAD (1 cycle): o_mix_sample_1/2 = capture regs; both load strobes high; o_mix_level_1/2 updated from shadow levels.
- EXEC (1 cycle): o_mix_execute high.
- CAPTURE (1 cycle): i_mix_output registered into o_dac_data; o_dac_valid set; -> PRESENT.
- PRESENT: o_dac_data and o_dac_valid held stable until i_dac_ready is sampled high; then valid clears -> IDLE.
- Latency, with both valids already high: tick sampled at cycle T; REQ at T+1; LOAD T+2; EXEC T+3; CAPTURE T+4; o_dac_valid high from T+5.
- Config: i_cfg_write loads shadow levels, each clamped to MAX_LEVEL (values 6/7 become 5). Writes are accepted in any state. Mixer levels change only in LOAD, so a write mid-frame takes effect next frame. A write in the same cycle as LOAD is used by the next frame.
- Overrun: i_tick in any state other than IDLE pulses o_overrun for 1 cycle, and the tick is discarded.
- Load and execute strobes are never high simultaneously and never high outside LOAD/EXEC.
- Reset mid-frame: immediate abort to IDLE; any pending DAC word is lost (valid drops).

Test Plan:
- Reset, tick; src1=0x40 and src2=0x80 valid from T+1; mixer model returns 0x0A0 -> loads at T+2, execute at T+3, o_dac_data=0x0A0 and o_dac_valid=1 at T+5; clears after i_dac_ready.
- src2_valid never asserted, TIMEOUT=16 -> REQ for 16 cycles; sample_2 = previous frame value (0 after reset); o_underrun_count=1; second such frame gives 2.
- i_cfg_write with levels 7/3 during REQ -> o_mix_level stays unchanged this frame; next LOAD shows 5/3.
- i_dac_ready held low 40 cycles while ticks arrive every 10 cycles -> o_dac_data stable, each tick gives one o_overrun pulse, no extra frames run.
- Assert i_reset during EXEC -> all outputs 0 asynchronously; next tick runs a clean frame.
- src1_valid pulse outside REQ, then valid in REQ with new data -> only the in-REQ value reaches o_mix_sample_1.
